// File: rtl/charmquark1984_seg_reader.sv
`default_nettype none
// ============================================================================
// Module   : charmquark1984_seg_reader
// Purpose  : Receive-side monitor for a seven-segment 0-9 digit stream.
//            Debounces the segment bus and decodes accepted patterns to BCD.
//            Checks that digits advance modulo 10, and reports lock status
//            together with sticky error flags.
// Option   : define SEG_READER_PERIOD_CHECK_EN to build the digit-period
//            checker. Without it, period_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module charmquark1984_seg_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int LOCK_COUNT    = 3,
    parameter int MAX_COUNT     = 1000,
    parameter int PERIOD_TOL    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       locked,
    output logic       seq_err,
    output logic       bad_pattern,
    output logic       period_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] c_stab_max = 4'(STABLE_CYCLES);
    localparam logic [3:0] c_stab_acc = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] c_lock     = 4'(LOCK_COUNT);

    // This scope is intentionally empty. An out-of-range configuration
    // elaborates an extra named scope, so it shows up in the hierarchy.
    if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 15) ||
        (LOCK_COUNT < 1) || (LOCK_COUNT > 15) ||
        (MAX_COUNT < 1) || (PERIOD_TOL < 0) ||
        (PERIOD_TOL > MAX_COUNT)) begin : g_param_range_violation
    end

    logic [6:0] seg_q;
    logic       seg_vld_q;      // seg_q holds a real post-reset sample
    logic [3:0] stab_q;
    logic [3:0] stab_d;
    logic       have_acc_q;
    logic [6:0] last_acc_q;
    logic [3:0] digit_q;
    logic       digit_valid_q;
    logic [3:0] prev_q;
    logic       bad_q;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] good_q;
    logic [3:0] good_d;
    logic       seq_err_q;
    logic       seq_err_d;

    logic       w_same;
    logic       w_stable;
    logic       w_accept;
    logic       w_acc_digit;
    logic       w_dec_valid;
    logic       w_blank;
    logic [3:0] w_dec_digit;
    logic [3:0] w_expected;

    // Debounce: count consecutive identical samples, saturating.
    always_comb begin
        w_same = seg_vld_q && (segments == seg_q);
        stab_d = 4'd0;
        if (w_same) begin
            stab_d = (stab_q == c_stab_max) ? stab_q : stab_q + 4'd1;
        end
    end

    // A pattern that has sampled identically STABLE_CYCLES times is accepted
    // once. It is not accepted again while it stays the last accepted one.
    assign w_stable    = seg_vld_q && (stab_q >= c_stab_acc);
    assign w_accept    = w_stable && (!have_acc_q || (seg_q != last_acc_q));
    assign w_acc_digit = w_accept && w_dec_valid;
    assign w_expected  = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;

    // Segment pattern to BCD decode; blank and illegal patterns flagged.
    always_comb begin
        w_dec_digit = 4'd0;
        w_dec_valid = 1'b1;
        w_blank     = 1'b0;
        case (seg_q)
            7'h3F: w_dec_digit = 4'd0;
            7'h06: w_dec_digit = 4'd1;
            7'h5B: w_dec_digit = 4'd2;
            7'h4F: w_dec_digit = 4'd3;
            7'h66: w_dec_digit = 4'd4;
            7'h6D: w_dec_digit = 4'd5;
            7'h7D: w_dec_digit = 4'd6;
            7'h07: w_dec_digit = 4'd7;
            7'h7F: w_dec_digit = 4'd8;
            7'h6F: w_dec_digit = 4'd9;
            7'h00: begin
                w_dec_valid = 1'b0;
                w_blank     = 1'b1;
            end
            default: w_dec_valid = 1'b0;
        endcase
    end

`ifdef SEG_READER_PERIOD_CHECK_EN
    localparam logic [16:0] c_per_lo = 17'(MAX_COUNT + 1 - PERIOD_TOL);
    localparam logic [16:0] c_per_hi = 17'(MAX_COUNT + 1 + PERIOD_TOL);

    logic [15:0] int_q;
    logic        period_err_q;
    logic        period_err_d;
    logic [16:0] w_interval;
    logic        w_overdue;

    // Cycles elapsed since the previous accepted digit, counting this edge.
    assign w_interval = {1'b0, int_q} + 17'd1;
    assign w_overdue  = ({1'b0, int_q} > c_per_hi);

    // Interval counter: restarts at each accepted digit, saturates at max.
    always_ff @(posedge clk) begin
        if (!reset) begin
            int_q        <= 16'd0;
            period_err_q <= 1'b0;
        end else begin
            period_err_q <= period_err_d;
            if (w_acc_digit) begin
                int_q <= 16'd0;
            end else if (int_q != 16'hFFFF) begin
                int_q <= int_q + 16'd1;
            end
        end
    end

    assign period_err = period_err_q;
`else
    assign period_err = 1'b0;
`endif

    // Input sampling, acceptance bookkeeping and sticky bad-pattern flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q         <= 7'd0;
            seg_vld_q     <= 1'b0;
            stab_q        <= 4'd0;
            have_acc_q    <= 1'b0;
            last_acc_q    <= 7'd0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            prev_q        <= 4'd0;
            bad_q         <= 1'b0;
        end else begin
            seg_q         <= segments;
            seg_vld_q     <= 1'b1;
            stab_q        <= stab_d;
            digit_valid_q <= w_acc_digit;
            if (w_accept) begin
                have_acc_q <= 1'b1;
                last_acc_q <= seg_q;
                if (w_dec_valid) begin
                    digit_q <= w_dec_digit;
                    prev_q  <= w_dec_digit;
                end else if (!w_blank) begin
                    bad_q <= 1'b1;
                end
            end
        end
    end

    // Sequence FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            good_q    <= 4'd0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            seq_err_q <= seq_err_d;
        end
    end

    // Sequence FSM next state: lock after LOCK_COUNT correct steps in a row.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        seq_err_d = seq_err_q;
`ifdef SEG_READER_PERIOD_CHECK_EN
        period_err_d = period_err_q;
`endif
        if (w_acc_digit) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    good_d  = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (w_dec_digit == w_expected) begin
                        good_d = good_q + 4'd1;
                        if (good_d == c_lock) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_dec_digit != w_expected) begin
                        seq_err_d = 1'b1;
                        state_d   = ST_ACQUIRE;
                        good_d    = 4'd0;
                    end
`ifdef SEG_READER_PERIOD_CHECK_EN
                    if ((w_interval < c_per_lo) || (w_interval > c_per_hi)) begin
                        period_err_d = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = 4'd0;
                end
            endcase
        end
`ifdef SEG_READER_PERIOD_CHECK_EN
        else if ((state_q == ST_LOCKED) && w_overdue) begin
            period_err_d = 1'b1;
            state_d      = ST_ACQUIRE;
            good_d       = 4'd0;
        end
`endif
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign locked      = (state_q == ST_LOCKED);
    assign seq_err     = seq_err_q;
    assign bad_pattern = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_charmquark1984_seg_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_charmquark1984_seg_reader
// Purpose  : Scoreboard bench for charmquark1984_seg_reader. The stimulus
//            drives runs of held segment patterns and predicts every accept
//            from run lengths. A monitor checks each edge against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_charmquark1984_seg_reader;

    localparam int STABLE_CYCLES = 4;
    localparam int LOCK_COUNT    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] segments = 7'd0;
    logic [3:0] digit;
    logic       digit_valid;
    logic       locked;
    logic       seq_err;
    logic       bad_pattern;
    logic       period_err;

    charmquark1984_seg_reader #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOCK_COUNT   (LOCK_COUNT),
        .MAX_COUNT    (1000),
        .PERIOD_TOL   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .segments   (segments),
        .digit      (digit),
        .digit_valid(digit_valid),
        .locked     (locked),
        .seq_err    (seq_err),
        .bad_pattern(bad_pattern),
        .period_err (period_err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n = edge_n + 1;

    typedef struct {
        int         at_edge;
        bit         is_digit;
        logic [3:0] dig;
        bit         lck;
        bit         serr;
        bit         bpat;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state: what the monitor should see, at transaction level.
    bit         m_have_acc;
    logic [6:0] m_last_acc;
    int         m_last_drv;
    bit         m_seen;
    int         m_prev;
    int         m_good;
    bit         m_locked;
    bit         m_seq;
    bit         m_bad;
    logic [3:0] m_digit;

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
        if (p == 7'h00) return -1;
        return -2;
    endfunction

    task automatic model_clear();
        m_have_acc = 0; m_last_acc = 0; m_last_drv = -1;
        m_seen = 0; m_prev = 0; m_good = 0;
        m_locked = 0; m_seq = 0; m_bad = 0; m_digit = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Hold pattern p for h edges and predict the acceptance it causes.
    task automatic hold(input logic [6:0] p, input int h);
        int   d;
        exp_t e;
        segments   = p;
        m_last_drv = int'(p);
        if (h >= STABLE_CYCLES && (!m_have_acc || p != m_last_acc)) begin
            m_have_acc = 1;
            m_last_acc = p;
            d = decode(p);
            if (d == -2) m_bad = 1;
            if (d >= 0) begin
                if (!m_seen) begin
                    m_seen = 1;
                    m_good = 0;
                end else if (d == (m_prev + 1) % 10) begin
                    if (!m_locked) begin
                        m_good++;
                        if (m_good == LOCK_COUNT) m_locked = 1;
                    end
                end else begin
                    if (m_locked) m_seq = 1;
                    m_locked = 0;
                    m_good   = 0;
                end
                m_prev  = d;
                m_digit = 4'(d);
            end
            if (d != -1) begin
                e.at_edge  = edge_n + 1 + STABLE_CYCLES;
                e.is_digit = (d >= 0);
                e.dig      = m_digit;
                e.lck      = m_locked;
                e.serr     = m_seq;
                e.bpat     = m_bad;
                exp_q.push_back(e);
            end
        end
        repeat (h) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    // Reset mid-flight: pending accepts are cancelled and outputs must clear.
    task automatic do_reset();
        while (exp_q.size() > 0 && exp_q[$].at_edge > edge_n) void'(exp_q.pop_back());
        reset    = 1'b0;
        segments = 7'h00;
        step();
        chk("rst_digit", {4'd0, digit}, 8'd0);
        chk("rst_valid", {7'd0, digit_valid}, 8'd0);
        chk("rst_locked", {7'd0, locked}, 8'd0);
        chk("rst_seq_err", {7'd0, seq_err}, 8'd0);
        chk("rst_bad_pattern", {7'd0, bad_pattern}, 8'd0);
        chk("rst_period_err", {7'd0, period_err}, 8'd0);
        step();
        reset = 1'b1;
        model_clear();
    endtask

    // Monitor: every edge either matches the queue head or must show no pulse.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at_edge < edge_n) begin
            e = exp_q.pop_front();
            n_total++;
            n_bad++;
            $display("FAIL missed_accept: no accept observed, expected one at edge %0d", e.at_edge);
        end
        if (exp_q.size() > 0 && exp_q[0].at_edge == edge_n) begin
            e = exp_q.pop_front();
            chk("acc_valid", {7'd0, digit_valid}, {7'd0, e.is_digit});
            chk("acc_digit", {4'd0, digit}, {4'd0, e.dig});
            chk("acc_locked", {7'd0, locked}, {7'd0, e.lck});
            chk("acc_seq_err", {7'd0, seq_err}, {7'd0, e.serr});
            chk("acc_bad_pattern", {7'd0, bad_pattern}, {7'd0, e.bpat});
            chk("acc_period_err", {7'd0, period_err}, 8'd0);
        end else begin
            chk("idle_valid", {7'd0, digit_valid}, 8'd0);
        end
    end

    logic [6:0] pick;
    int         r;
    int         wait_cnt;

    initial begin
        model_clear();
        do_reset();
        hold(7'h00, 50);
        // first digit, then a short glitch and a return to the accepted value
        hold(7'h3F, 10);
        hold(7'h5B, 3);
        hold(7'h3F, 10);
        hold(7'h06, 10); hold(7'h5B, 10); hold(7'h4F, 10); hold(7'h66, 10);
        // out of sequence while locked, then recover across the 9->0 wrap
        hold(7'h7D, 10);
        hold(7'h7F, 10); hold(7'h6F, 10); hold(7'h3F, 10);
        hold(7'h06, 10); hold(7'h5B, 10);
        // invalid pattern, then reset in the middle of a debounce
        hold(7'h49, 6);
        hold(7'h4F, 2);
        do_reset();
        hold(7'h00, 8);
        // exactly STABLE_CYCLES and one short of it
        hold(7'h6D, STABLE_CYCLES);
        hold(7'h7D, STABLE_CYCLES - 1);
        hold(7'h7D ^ 7'h01, 1);
        hold(7'h7D, STABLE_CYCLES);
        // randomized runs
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
                continue;
            end
            if (r < 62 && m_seen) pick = seg_tab[(m_prev + 1) % 10];
            else if (r < 77) pick = seg_tab[$urandom_range(0, 9)];
            else if (r < 87) pick = 7'h00;
            else pick = 7'($urandom_range(0, 127));
            if (int'(pick) == m_last_drv) pick = pick ^ 7'h40;
            hold(pick, $urandom_range(1, 12));
        end
        hold(7'h00 ^ ((m_last_drv == 0) ? 7'h01 : 7'h00), 2);
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 100) begin
            step();
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain_timeout: %0d accepts still pending, expected 0", exp_q.size());
        end
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
